// File: rtl/bus_memory_controller_if.sv
// Shared-bus handshake between the microcoded control unit (master) and the memory controller (slave).
interface bus_memory_controller_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] bus_in;
   logic              ldMA;
   logic              enMem;
   logic              MemWrt;
   logic              busy;
   logic [DATA_W-1:0] mem_out;
   logic              mem_oe;

   modport master (
      output bus_in, ldMA, enMem, MemWrt,
      input  busy, mem_out, mem_oe
   );

   modport slave (
      input  bus_in, ldMA, enMem, MemWrt,
      output busy, mem_out, mem_oe
   );
endinterface

// File: rtl/bus_memory_controller.sv
// Word-addressed memory behind a shared bus: MA register, fixed-latency access FSM, registered read data.
//
// state  | meaning
// IDLE   | waiting for enMem; request is captured on the edge it is seen
// ACCESS | counting down LATENCY cycles; write/read resolves on the cnt==0 edge
// DONE   | result ready; held until the control unit drops enMem
module bus_memory_controller #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic                      clock,
   input logic                      reset,
   bus_memory_controller_if.slave   mbus
);
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   ma;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   mem_out_q;
   logic [ADDR_W-1:0]   idx;
   logic [3:0]          cnt;
   logic                op_wr;
   logic                start;
   logic                finish;
   logic                ma_unused;

   logic [DATA_W-1:0]   mem [DEPTH];

   // byte-address view of MA: low two bits and bits above the array are dropped
   assign ma_unused = ^{ma[DATA_W-1:ADDR_W+2], ma[1:0]};

   assign start  = (state == IDLE) && mbus.enMem;
   assign finish = (state == ACCESS) && (cnt == 4'd0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ma        <= '0;
         cnt       <= '0;
         op_wr     <= 1'b0;
         wdata     <= '0;
         idx       <= '0;
         mem_out_q <= '0;
      end else begin
         state <= state_nxt;
         if (mbus.ldMA)
            ma <= mbus.bus_in;
         if (start) begin
            idx   <= ma[ADDR_W+1:2];
            op_wr <= mbus.MemWrt;
            wdata <= mbus.bus_in;
            cnt   <= 4'(LATENCY - 1);
         end else if (state == ACCESS && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (finish && !op_wr)
            mem_out_q <= mem[idx];
      end
   end

   // no reset on the array; reset forces IDLE so an in-flight write never commits
   always_ff @(posedge clock) begin
      if (finish && op_wr)
         mem[idx] <= wdata;
   end

   always_comb begin
      state_nxt   = state;
      mbus.busy   = 1'b0;
      mbus.mem_oe = 1'b0;
      case (state)
         IDLE: begin
            mbus.busy = mbus.enMem;
            if (mbus.enMem)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            mbus.busy = 1'b1;
            if (cnt == 4'd0)
               state_nxt = DONE;
         end
         DONE: begin
            mbus.mem_oe = !op_wr && mbus.enMem;
            if (!mbus.enMem)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mbus.mem_out = mem_out_q;
endmodule

// File: doc/bus_memory_controller.md
BUS_MEMORY_CONTROLLER -- requirements
Module: bus_memory_controller

Interface
REQ-001 Parameter DATA_W, default 32: width of the shared bus and of a memory word.
REQ-002 Parameter DEPTH, default 256: number of memory words; ADDR_W = log2(DEPTH).
REQ-003 Parameter LATENCY, default 2: cycles spent in ACCESS per transaction; legal range 1..15.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 bus_in  input  DATA_W  current value of the shared bus; supplies address and write data.
REQ-007 ldMA  input  1  loads the memory-address register MA from bus_in.
REQ-008 enMem  input  1  memory request from the microcoded control unit, held until the access completes.
REQ-009 MemWrt  input  1  1 = write request, 0 = read request; sampled together with enMem.
REQ-010 busy  output  1  memory not ready; the control unit spins while this is high.
REQ-011 mem_out  output  DATA_W  read data destined for the bus.
REQ-012 mem_oe  output  1  tristate enable for mem_out onto the bus.

Function
REQ-013 MA SHALL be a DATA_W-bit register loaded from bus_in on any edge where ldMA=1, in every state.
REQ-014 Word index SHALL be MA[ADDR_W+1:2]; MA[1:0] and bits above ADDR_W+1 SHALL be ignored, so out-of-range addresses wrap modulo DEPTH.
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-016 IDLE -> ACCESS on enMem=1: capture word index, MemWrt into op_wr, and bus_in into wdata; load cnt = LATENCY-1.
REQ-017 ACCESS: cnt decrements each cycle; at cnt=0, go to DONE; for op_wr=1 the write to memory[index] SHALL commit on this same edge.
REQ-018 At the ACCESS -> DONE edge with op_wr=0, mem_out SHALL register memory[index].
REQ-019 DONE: stay while enMem=1 (no new transaction starts); go to IDLE on the first cycle enMem=0.
REQ-020 busy SHALL be combinational: 1 when state=ACCESS, or when state=IDLE and enMem=1; 0 otherwise.
REQ-021 mem_oe SHALL be 1 only when state=DONE, op_wr=0 and enMem=1.
REQ-022 Latency: enMem rising in IDLE -> busy low after exactly LATENCY+1 rising edges.
REQ-023 ldMA during ACCESS or DONE SHALL update MA but SHALL NOT change the index of the transaction in flight.
REQ-024 ldMA and enMem both high in IDLE: the transaction SHALL use the pre-edge MA; the new MA applies to the next transaction.
REQ-025 Changes on MemWrt or bus_in after the IDLE -> ACCESS edge SHALL NOT affect the transaction.
REQ-026 enMem dropping during ACCESS SHALL NOT abort the transaction; the FSM completes ACCESS, then DONE -> IDLE on the next edge.
REQ-027 mem_out SHALL hold its last read value until the next read completes.

Reset
REQ-028 When reset=0, asynchronously: state=IDLE, MA=0, cnt=0, op_wr=0, wdata=0, mem_out=0, so mem_oe=0 and busy=enMem.
REQ-029 Reset asserted mid-ACCESS SHALL abort the transaction; a pending write SHALL NOT commit.
REQ-030 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-031 Write then read, LATENCY=2: ldMA with bus_in=0x10; enMem=1, MemWrt=1, bus_in=0xDEADBEEF -> busy high 3 edges, then low; drop enMem; read 0x10 -> mem_out=0xDEADBEEF and mem_oe=1 in DONE.
REQ-032 Wrap: write 0x55 at MA=0x400 (DEPTH=256) -> a read at MA=0x000 returns 0x55; a read at MA=0x003 also returns 0x55.
REQ-033 Hold in DONE: keep enMem=1 for 5 cycles after a read -> stays DONE, busy=0, only one transaction, mem_oe=1 throughout; enMem=0 -> IDLE, mem_oe=0.
REQ-034 ldMA mid-access: start a read at 0x20, pulse ldMA with 0x40 during ACCESS -> data from 0x20 is returned; MA=0x40 afterwards.
REQ-035 Reset mid-write: memory[5]=0x11; start write 0x99 at MA=0x14; assert reset=0 in ACCESS -> state=IDLE, MA=0, memory[5] still 0x11.
REQ-036 LATENCY=1 build: any request -> busy high for exactly 2 edges.
